// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the sequence-detector scheduler.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_WORD_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot winner, registered pointer that
// moves to winner+1 whenever the owner accepts a grant via advance.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req,
    input  logic                     advance,
    output logic [NREQ-1:0]          winner,
    output logic [$clog2(NREQ)-1:0]  winner_idx,
    output logic                     any
);
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] ptr_reg;
    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // rot[k] is the request sitting k places after the pointer
    assign rot = NREQ'({req, req} >> ptr_reg);

    always_comb begin
        any = 1'b0;
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                off = IDX_W'(k);
            end
        end
        sum = {1'b0, ptr_reg} + {1'b0, off};
        if (sum >= (IDX_W+1)'(NREQ)) begin
            sum = sum - (IDX_W+1)'(NREQ);
        end
        winner_idx = sum[IDX_W-1:0];
        winner     = any ? (NREQ'(1) << winner_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_reg <= '0;
        end else if (advance && any) begin
            ptr_reg <= (winner_idx == IDX_W'(NREQ - 1)) ? '0 : winner_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one external Mealy "10101" detector between NREQ requesters.
// Optional first-match position tracking is enabled by SEQ_SCHED_FIRSTPOS_EN.
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WORD_W-1:0]     word,
    output logic [NREQ-1:0]            grant,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NREQ)-1:0]    done_id,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(WORD_W)-1:0]  first_pos,
    output logic                       det_ip,
    output logic                       det_resetn,
    input  logic                       det_op
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int POS_W = $clog2(WORD_W);

    state_t              state_reg;
    logic [WORD_W-1:0]   shift_reg;
    logic [POS_W-1:0]    bit_reg;
    logic [CNT_W-1:0]    acc_reg;
    logic [CNT_W-1:0]    acc_next;
    logic [IDX_W-1:0]    job_id_reg;
    logic [NREQ-1:0]     grant_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [IDX_W-1:0]    done_id_reg;
    logic [CNT_W-1:0]    match_reg;
    logic                det_resetn_reg;
    logic                last_bit;

    logic [NREQ-1:0]     winner;
    logic [IDX_W-1:0]    win_idx;
    logic                any;
    logic [WORD_W-1:0]   words [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign words[gi] = word[gi*WORD_W +: WORD_W];
        end
    endgenerate

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .advance    (state_reg == IDLE),
        .winner     (winner),
        .winner_idx (win_idx),
        .any        (any)
    );

    // det_op is combinational from det_ip, so it is sampled in the same cycle
    assign acc_next = acc_reg + CNT_W'(det_op);
    assign last_bit = (state_reg == SHIFT) && (bit_reg == POS_W'(WORD_W - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_reg        <= '0;
            acc_reg        <= '0;
            job_id_reg     <= '0;
            grant_reg      <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            done_id_reg    <= '0;
            match_reg      <= '0;
            det_resetn_reg <= 1'b0;
        end else begin
            grant_reg <= '0;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    det_resetn_reg <= 1'b1;
                    if (any) begin
                        state_reg      <= CLEAR;
                        grant_reg      <= winner;
                        busy_reg       <= 1'b1;
                        det_resetn_reg <= 1'b0;
                        shift_reg      <= words[win_idx];
                        bit_reg        <= '0;
                        acc_reg        <= '0;
                        job_id_reg     <= win_idx;
                    end
                end
                CLEAR: begin
                    state_reg      <= SHIFT;
                    det_resetn_reg <= 1'b1;
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bit_reg   <= bit_reg + POS_W'(1);
                    acc_reg   <= acc_next;
                    if (last_bit) begin
                        state_reg   <= REPORT;
                        done_reg    <= 1'b1;
                        done_id_reg <= job_id_reg;
                        match_reg   <= acc_next;
                    end
                end
                REPORT: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_SCHED_FIRSTPOS_EN
    logic             hit_reg;
    logic [POS_W-1:0] pos_reg;
    logic [POS_W-1:0] pos_next;
    logic [POS_W-1:0] first_pos_reg;

    always_comb begin
        pos_next = pos_reg;
        if (det_op && !hit_reg) begin
            pos_next = bit_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_reg       <= 1'b0;
            pos_reg       <= '0;
            first_pos_reg <= '0;
        end else if (state_reg == IDLE && any) begin
            hit_reg <= 1'b0;
            pos_reg <= '0;
        end else if (state_reg == SHIFT) begin
            pos_reg <= pos_next;
            if (det_op) begin
                hit_reg <= 1'b1;
            end
            if (last_bit) begin
                first_pos_reg <= pos_next;
            end
        end
    end

    assign first_pos = first_pos_reg;
`else
    assign first_pos = '0;
`endif

    assign grant      = grant_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign done_id    = done_id_reg;
    assign match_cnt  = match_reg;
    assign det_ip     = shift_reg[WORD_W-1];
    assign det_resetn = det_resetn_reg;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler with a behavioural "10101" Mealy
// detector attached to the det_* pins.
module tb_seq_detect_scheduler;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;

`ifdef SEQ_SCHED_FIRSTPOS_EN
    localparam bit FP_EN = 1'b1;
`else
    localparam bit FP_EN = 1'b0;
`endif

    logic                   clk;
    logic                   resetn;
    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word;
    logic [NREQ-1:0]        grant;
    logic                   busy;
    logic                   done;
    logic [1:0]             done_id;
    logic [CNT_W-1:0]       match_cnt;
    logic [3:0]             first_pos;
    logic                   det_ip;
    logic                   det_resetn;
    logic                   det_op;

    int vectors     = 0;
    int miscompares = 0;

    seq_detect_scheduler #(
        .NREQ   (NREQ),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .word       (word),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .match_cnt  (match_cnt),
        .first_pos  (first_pos),
        .det_ip     (det_ip),
        .det_resetn (det_resetn),
        .det_op     (det_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping "10101" detector: states track the longest matched prefix
    logic [2:0] det_st;
    always_ff @(posedge clk) begin
        if (!det_resetn) begin
            det_st <= 3'd0;
        end else begin
            case (det_st)
                3'd0:    det_st <= det_ip ? 3'd1 : 3'd0;
                3'd1:    det_st <= det_ip ? 3'd1 : 3'd2;
                3'd2:    det_st <= det_ip ? 3'd3 : 3'd0;
                3'd3:    det_st <= det_ip ? 3'd1 : 3'd4;
                3'd4:    det_st <= det_ip ? 3'd3 : 3'd0;
                default: det_st <= 3'd0;
            endcase
        end
    end
    assign det_op = (det_st == 3'd4) && det_ip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_grant"},      grant,      0);
        check({pfx, "_busy"},       busy,       0);
        check({pfx, "_done"},       done,       0);
        check({pfx, "_done_id"},    done_id,    0);
        check({pfx, "_match_cnt"},  match_cnt,  0);
        check({pfx, "_first_pos"},  first_pos,  0);
        check({pfx, "_det_ip"},     det_ip,     0);
        check({pfx, "_det_resetn"}, det_resetn, 0);
    endtask

    task automatic set_word(input int id, input logic [WORD_W-1:0] w);
        word[id*WORD_W +: WORD_W] = w;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (grant != 0) begin
                g = grant;
                break;
            end
        end
        check("grant_seen", 32'(g != 0), 1);
    endtask

    // Counts cycles until done, starting from the supplied count
    task automatic wait_done(input int start, output int lat);
        lat = start;
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_job(input int id, input logic [WORD_W-1:0] w,
                           input int exp_cnt, input int exp_pos);
        logic [NREQ-1:0] g;
        int lat;
        set_word(id, w);
        req[id] = 1'b1;
        wait_grant(g);
        check("grant", g, 32'(1) << id);
        check("busy_clear", busy, 1);
        check("det_resetn_clear", det_resetn, 0);
        req[id] = 1'b0;
        @(negedge clk);
        check("det_ip_msb", det_ip, w[WORD_W-1]);
        check("det_resetn_shift", det_resetn, 1);
        wait_done(1, lat);
        check("latency", lat, WORD_W + 1);
        check("done_id", done_id, id);
        check("match_cnt", match_cnt, exp_cnt);
        check("first_pos", first_pos, FP_EN ? exp_pos : 0);
        $display("job req=%0d word=%h done_id=%0d match_cnt=%0d first_pos=%0d latency=%0d",
                 id, w, done_id, match_cnt, first_pos, lat);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("hold_cnt", match_cnt, exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] g;
        int lat;
        int cyc, last, gap, max_gap, ngrant, seen;
        bit started;

        resetn = 1'b0;
        req    = '0;
        word   = '0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_det_resetn", det_resetn, 1);
        check("idle_busy", busy, 0);

        run_job(0, 16'hA800, 1, 4);
        run_job(2, 16'hAAAA, 6, 4);
        run_job(1, 16'h0000, 0, 0);
        run_job(1, 16'hFFFF, 0, 0);

        // All four requesting from reset: strict rotation, WORD_W+3 spacing
        resetn = 1'b0;
        for (int i = 0; i < NREQ; i++) set_word(i, 16'hA800);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cyc = 0; last = 0; gap = 0; max_gap = 0; ngrant = 0; started = 1'b0;
        while (ngrant < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (grant != 0) begin
                check("rr_grant", grant, 32'(1) << (ngrant % NREQ));
                if (ngrant > 0) check("rr_spacing", cyc - last, WORD_W + 3);
                $display("rr grant=%b cycle=%0d", grant, cyc);
                last = cyc;
                ngrant++;
                started = 1'b1;
                if (ngrant == 5) req = '0;
            end
            if (started) begin
                gap = busy ? 0 : gap + 1;
                if (gap > max_gap) max_gap = gap;
            end
        end
        check("rr_count", ngrant, 5);
        check("busy_gap", max_gap, 1);
        wait_done(0, lat);
        check("rr_last_id", done_id, 0);
        check("rr_last_cnt", match_cnt, 1);
        @(negedge clk);

        // Reset in the middle of SHIFT: job discarded, pointer back to 0
        set_word(2, 16'hAAAA);
        req[2] = 1'b1;
        wait_grant(g);
        check("mid_grant", g, 4'b0100);
        req = '0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        resetn = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_reset", seen, 0);
        $display("mid-shift reset: done pulses after reset=%0d", seen);
        set_word(0, 16'hA800);
        set_word(3, 16'hFFFF);
        req = 4'b1001;
        wait_grant(g);
        check("post_reset_grant", g, 4'b0001);
        req = '0;
        wait_done(0, lat);
        check("post_reset_id", done_id, 0);
        check("post_reset_cnt", match_cnt, 1);
        @(negedge clk);

        // Short req[3] pulse while busy must never be granted
        set_word(1, 16'h0000);
        req[1] = 1'b1;
        wait_grant(g);
        check("pulse_job_grant", g, 4'b0010);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        req[3] = 1'b1;
        @(negedge clk);
        req[3] = 1'b0;
        wait_done(0, lat);
        check("pulse_job_id", done_id, 1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (grant != 0) seen++;
        end
        check("no_grant_r3", seen, 0);
        $display("dropped req[3] pulse: grants afterwards=%0d", seen);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
